// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, 8N1 frame constants
// and the clocks-per-bit helper.
package uart_pkg;

   // Serializer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // 8N1 framing: start + 8 data + stop
   localparam int unsigned FRAME_BITS = 10;
   localparam int unsigned DATA_BITS  = FRAME_BITS - 2;

   // Clock cycles per serial bit (truncating division)
   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/cmd_uart_tx_fifo.sv
// cmd_fifo: synchronous FIFO buffering command bytes ahead of the serializer.
//   clk, reset     : clock, asynchronous active-high reset
//   push, wdata    : write request and data (ignored when full)
//   pop, rdata     : read request (ignored when empty); rdata shows the head
//   full, empty    : registered status flags
//   count          : registered occupancy, one bit wider than the pointers
module cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_d;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Occupancy update; simultaneous push and pop leaves it unchanged
   always_comb begin
      count_d = count;
      case ({do_push, do_pop})
         2'b10:   count_d = count + CNT_W'(1);
         2'b01:   count_d = count - CNT_W'(1);
         default: count_d = count;
      endcase
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_d;
         full  <= (count_d == CNT_W'(DEPTH));
         empty <= (count_d == '0);
      end
   end

endmodule

// File: rtl/cmd_uart_tx.sv
// cmd_uart_tx: buffers controller command bytes and sends them as 8N1 UART.
//   clk, reset  : clock, asynchronous active-high reset
//   cmd_data    : command byte, cmd_valid qualifies it, cmd_ready accepts it
//   TxD         : serial line (registered, idle high)
//   busy        : frame in progress or bytes buffered
//   frame_done  : one-cycle pulse during the last cycle of each stop bit
//   fifo_count  : bytes buffered, excluding the one being shifted out
module cmd_uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    cmd_data,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   output logic                          TxD,
   output logic                          busy,
   output logic                          frame_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
   localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int unsigned IDX_W = $clog2(DATA_BITS);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       sh_q, sh_d;
   logic             pop;
   logic             push;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_head;
   logic             txd_d;
   logic             frame_done_d;
   logic             bit_end;

   // Ready comes only from registered FIFO state, never from cmd_valid
   assign cmd_ready = ~fifo_full;
   assign push      = cmd_valid & cmd_ready;
   assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);
   assign bit_end   = (cnt_q == CNT_W'(DIV - 1));

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (cmd_data),
      .pop   (pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // State and datapath registers; TxD and frame_done come straight from flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         sh_q       <= '0;
         TxD        <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         sh_q       <= sh_d;
         TxD        <= txd_d;
         frame_done <= frame_done_d;
      end
   end

   // Next-state: bit-period counter restarts on every state or bit change
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      sh_d    = sh_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               sh_d    = fifo_head;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                  state_d = ST_STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  sh_d  = {1'b0, sh_q[7:1]};
               end
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               // Chain straight into the next start bit when more is queued
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  sh_d    = fifo_head;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from next state so the registered outputs line up with it
   always_comb begin
      txd_d        = 1'b1;
      frame_done_d = 1'b0;
      case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = sh_d[0];
         default:  txd_d = 1'b1;
      endcase
      frame_done_d = (state_d == ST_STOP) && (cnt_d == CNT_W'(DIV - 1));
   end

endmodule
